// File: rtl/full_adder_bist.sv
// Built-in self-test controller for a single-bit full adder. Walks all eight
// (a, b, carryin) combinations, holds each for SETTLE_CYCLES cycles, samples
// sum/carryout on the edge that leaves CHECK and accumulates the results.
module full_adder_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             carryin,
  input  logic             sum,
  input  logic             carryout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       first_fail
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [2:0]       ff_q, ff_d;
  logic [2:0]       drive_q, drive_d;

  logic launch;
  logic expSum;
  logic expCarry;
  logic mismatch;

  assign launch   = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign expSum   = vec_q[0] ^ vec_q[1] ^ vec_q[2];
  assign expCarry = (vec_q[0] & vec_q[1]) | (vec_q[0] & vec_q[2]) | (vec_q[1] & vec_q[2]);
  assign mismatch = (sum != expSum) || (carryout != expCarry);

  // State register; reset overrides any start seen on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: APPLY waits out the settle count, CHECK is a single cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (cnt_q == CNT_LAST) state_d = CHECK;
      CHECK:   state_d = (vec_q == 3'd7) ? DONE : APPLY;
      DONE:    if (start) state_d = APPLY;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = (state_q == APPLY) || (state_q == CHECK);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_q == '0);
  end

  // Datapath next state: vector index, settle counter, result capture, drive.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    err_d = err_q;
    fv_d  = fv_q;
    ff_d  = ff_q;
    if (launch) begin
      vec_d = 3'd0;
      cnt_d = '0;
      err_d = '0;
      fv_d  = 1'b0;
      ff_d  = 3'd0;
    end else if (state_q == APPLY) begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == CHECK) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
        if (!fv_q) begin
          fv_d = 1'b1;
          ff_d = vec_q;
        end
      end
      if (vec_q != 3'd7) begin
        vec_d = vec_q + 3'd1;
        cnt_d = '0;
      end
    end
    drive_d = ((state_d == APPLY) || (state_d == CHECK)) ? vec_d : 3'd0;
  end

  // Datapath registers; the adder inputs come straight from drive_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= 3'd0;
      drive_q <= 3'd0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      drive_q <= drive_d;
    end
  end

  assign a          = drive_q[0];
  assign b          = drive_q[1];
  assign carryin    = drive_q[2];
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_full_adder_bist.sv
// Bench for full_adder_bist: two instances (default parameters, and
// SETTLE_CYCLES=1 / ERR_W=3) each driving a bench adder model that can be
// faulted. Expected run results are queued at launch; monitors compare.
module tb_full_adder_bist;

  localparam int GOLD     = 0;
  localparam int STUCK_CO = 1;
  localparam int INV_SUM  = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic startA, startB;
  logic aA, bA, ciA, sumA, coA, busyA, doneA, passA, fvA;
  logic [3:0] errA;
  logic [2:0] ffA;
  logic aB, bB, ciB, sumB, coB, busyB, doneB, passB, fvB;
  logic [2:0] errB;
  logic [2:0] ffB;
  logic prevDoneA = 1'b0;
  logic prevDoneB = 1'b0;
  int modeA = GOLD;
  int modeB = GOLD;
  int cycle = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int e0;
    int doneCycle;
    int err;
    int fv;
    int ff;
    int pass;
  } expRes_t;

  expRes_t qA[$];
  expRes_t qB[$];

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter, value after each rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  // Bench adder models with selectable faults.
  assign sumA = aA ^ bA ^ ciA ^ (modeA == INV_SUM);
  assign coA  = (modeA == STUCK_CO) ? 1'b0 : ((aA & bA) | (aA & ciA) | (bA & ciA));
  assign sumB = aB ^ bB ^ ciB ^ (modeB == INV_SUM);
  assign coB  = (modeB == STUCK_CO) ? 1'b0 : ((aB & bB) | (aB & ciB) | (bB & ciB));

  full_adder_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) dutA (
    .clk(clk), .reset_n(reset_n), .start(startA),
    .a(aA), .b(bA), .carryin(ciA), .sum(sumA), .carryout(coA),
    .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .fail_valid(fvA), .first_fail(ffA)
  );

  full_adder_bist #(.SETTLE_CYCLES(1), .ERR_W(3)) dutB (
    .clk(clk), .reset_n(reset_n), .start(startB),
    .a(aB), .b(bB), .carryin(ciB), .sum(sumB), .carryout(coB),
    .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .fail_valid(fvB), .first_fail(ffB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on one instance and queue the hand-computed run result.
  task automatic applyStimulus(input int dutSel, input int mode, input int err,
                               input int fv, input int ff, input int pass);
    if (dutSel == 0) begin
      modeA = mode;
      startA = 1'b1;
      tick();
      startA = 1'b0;
      qA.push_back('{cycle, cycle + 24, err, fv, ff, pass});
    end else begin
      modeB = mode;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      qB.push_back('{cycle, cycle + 16, err, fv, ff, pass});
    end
  endtask

  task automatic waitDone(input int dutSel, input int budget);
    int n = 0;
    while ((((dutSel == 0) ? doneA : doneB) !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput("done within budget", 32'(n < budget), 1);
  endtask

  task automatic checkIdleA(input string tag);
    checkOutput({tag, " A abc"}, {29'd0, ciA, bA, aA}, 0);
    checkOutput({tag, " A busy"}, busyA, 0);
    checkOutput({tag, " A done"}, doneA, 0);
    checkOutput({tag, " A pass"}, passA, 0);
    checkOutput({tag, " A err"}, errA, 0);
    checkOutput({tag, " A fv"}, fvA, 0);
    checkOutput({tag, " A ff"}, ffA, 0);
  endtask

  // Monitor A: per-cycle vector sequence while busy, full result at done rise.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (busyA === 1'b1) begin
        if (qA.size() == 0) begin
          checkOutput("A busy without run", qA.size(), 1);
        end else begin
          checkOutput("A vector", {29'd0, ciA, bA, aA}, (cycle - qA[0].e0) / 3);
          checkOutput("A pass while busy", passA, 0);
        end
      end
      if ((doneA === 1'b1) && !prevDoneA) begin
        if (qA.size() == 0) begin
          checkOutput("A done without run", qA.size(), 1);
        end else begin
          checkOutput("A done cycle", cycle, qA[0].doneCycle);
          checkOutput("A busy at done", busyA, 0);
          checkOutput("A err_count", errA, qA[0].err);
          checkOutput("A fail_valid", fvA, qA[0].fv);
          checkOutput("A first_fail", ffA, qA[0].ff);
          checkOutput("A pass", passA, qA[0].pass);
          void'(qA.pop_front());
        end
      end
    end
    prevDoneA <= (doneA === 1'b1);
  end

  // Monitor B: same checks with a two-cycle vector period.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (busyB === 1'b1) begin
        if (qB.size() == 0) begin
          checkOutput("B busy without run", qB.size(), 1);
        end else begin
          checkOutput("B vector", {29'd0, ciB, bB, aB}, (cycle - qB[0].e0) / 2);
          checkOutput("B pass while busy", passB, 0);
        end
      end
      if ((doneB === 1'b1) && !prevDoneB) begin
        if (qB.size() == 0) begin
          checkOutput("B done without run", qB.size(), 1);
        end else begin
          checkOutput("B done cycle", cycle, qB[0].doneCycle);
          checkOutput("B err_count", errB, qB[0].err);
          checkOutput("B fail_valid", fvB, qB[0].fv);
          checkOutput("B first_fail", ffB, qB[0].ff);
          checkOutput("B pass", passB, qB[0].pass);
          void'(qB.pop_front());
        end
      end
    end
    prevDoneB <= (doneB === 1'b1);
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    reset_n = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    checkIdleA("reset");
    checkOutput("reset B busy", busyB, 0);
    checkOutput("reset B err", errB, 0);

    // Golden adder, default settle.
    applyStimulus(0, GOLD, 0, 0, 0, 1);
    waitDone(0, 40);
    tick();

    // Carryout stuck at 0: vectors 3,5,6,7 fail; first failure visible after E0+12.
    applyStimulus(0, STUCK_CO, 4, 1, 3, 0);
    repeat (11) tick();
    checkOutput("stuck fv before v3 check", fvA, 0);
    tick();
    checkOutput("stuck fv after v3 check", fvA, 1);
    checkOutput("stuck ff after v3 check", ffA, 3);
    checkOutput("stuck err after v3 check", errA, 1);
    waitDone(0, 40);
    tick();

    // Reset low for the edge E0+10 aborts the run.
    applyStimulus(0, GOLD, 0, 0, 0, 1);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    qA.delete();
    checkIdleA("mid-run reset");

    // Reset and start on the same edge: reset wins.
    reset_n = 1'b0;
    startA = 1'b1;
    tick();
    reset_n = 1'b1;
    startA = 1'b0;
    checkOutput("reset beats start busy", busyA, 0);

    // Fresh golden run after the abort.
    applyStimulus(0, GOLD, 0, 0, 0, 1);
    waitDone(0, 40);
    tick();

    // Start held high: first run faulty, restart one cycle after done, counters cleared.
    modeA = STUCK_CO;
    startA = 1'b1;
    tick();
    qA.push_back('{cycle, cycle + 24, 4, 1, 3, 0});
    qA.push_back('{cycle + 25, cycle + 49, 0, 0, 0, 1});
    waitDone(0, 40);
    modeA = GOLD;
    tick();
    checkOutput("held start done one cycle", doneA, 0);
    checkOutput("held start busy again", busyA, 1);
    checkOutput("held start err cleared", errA, 0);
    checkOutput("held start fv cleared", fvA, 0);
    waitDone(0, 40);
    startA = 1'b0;
    tick();
    checkOutput("done holds without start", doneA, 1);
    checkOutput("pass holds without start", passA, 1);

    // Instance B: golden with single-cycle settle.
    applyStimulus(1, GOLD, 0, 0, 0, 1);
    waitDone(1, 30);
    tick();

    // Instance B: inverted sum, all vectors fail, 3-bit counter saturates.
    applyStimulus(1, INV_SUM, 7, 1, 0, 0);
    tick();
    checkOutput("inv fv before v0 check", fvB, 0);
    tick();
    checkOutput("inv fv after v0 check", fvB, 1);
    checkOutput("inv ff after v0 check", ffB, 0);
    checkOutput("inv err after v0 check", errB, 1);
    waitDone(1, 30);
    tick();
    tick();

    checkOutput("A queue drained", qA.size(), 0);
    checkOutput("B queue drained", qB.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
